// File: rtl/fetch_stage_bp.sv
// Instruction-fetch stage with a 2-bit saturating-counter branch predictor.
// Holds the PC and pre-decodes the fetched word for beq. A branch history
// table picks the next PC. Outcomes that decode resolves retrain the table
// and redirect fetch on a mispredict.
module fetch_stage_bp #(
  parameter int          BHT_IDX_BITS = 4,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  input  logic        resolveValid,
  input  logic        resolveTaken,
  input  logic [31:0] resolvePc,
  input  logic [31:0] resolveTarget,
  input  logic        resolvePredTaken,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic        predTakenD,
  output logic        validD,
  output logic        mispredict
);

  localparam int         BHT_ENTRIES = 1 << BHT_IDX_BITS;
  localparam logic [5:0] BEQ_OPCODE  = 6'b000100;

  logic [31:0]             pc;
  logic [31:0]             pc_plus4;
  logic [31:0]             pred_target;
  logic [31:0]             redirect_pc;
  logic [31:0]             next_pc;
  logic [1:0]              bht [BHT_ENTRIES];
  logic [BHT_IDX_BITS-1:0] fetch_idx;
  logic [BHT_IDX_BITS-1:0] resolve_idx;
  logic [1:0]              fetch_ctr;
  logic [1:0]              resolve_ctr;
  logic [1:0]              resolve_ctr_next;
  logic                    is_beq;
  logic                    pred_taken;

  // Pre-decode and predict on the word being fetched this cycle.
  assign imemAddr    = pc;
  assign pc_plus4    = pc + 32'd4;
  assign is_beq      = (imemData[31:26] == BEQ_OPCODE);
  assign pred_target = pc_plus4 + {{14{imemData[15]}}, imemData[15:0], 2'b00};
  assign fetch_idx   = pc[BHT_IDX_BITS+1:2];
  // The table read sees the value from before this edge's update. A
  // same-index write lands next cycle.
  assign fetch_ctr   = bht[fetch_idx];
  assign pred_taken  = is_beq & fetch_ctr[1];

  // Resolution side: detect mispredicts and pick the recovery PC.
  assign mispredict  = resolveValid & (resolveTaken != resolvePredTaken);
  assign redirect_pc = resolveTaken ? resolveTarget : (resolvePc + 32'd4);
  assign resolve_idx = resolvePc[BHT_IDX_BITS+1:2];
  assign resolve_ctr = bht[resolve_idx];

  // Sequential next-PC choice when fetch is free to advance.
  always_comb begin
    // NOTE: every always_comb output gets a default first. A path that leaves
    // an output unassigned infers a latch.
    next_pc = pc_plus4;
    if (pred_taken) next_pc = pred_target;
  end

  // Saturating counter step for the branch being resolved.
  always_comb begin
    resolve_ctr_next = resolve_ctr;
    if (resolveTaken) begin
      if (resolve_ctr != 2'b11) resolve_ctr_next = resolve_ctr + 2'd1;
    end else begin
      if (resolve_ctr != 2'b00) resolve_ctr_next = resolve_ctr - 2'd1;
    end
  end

  // PC and IF/ID register. A mispredict flushes and redirects even under stall.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments. Every register then samples
    // the pre-edge values, whatever the order of the statements.
    if (rst) begin
      pc         <= RESET_PC;
      instrD     <= '0;
      pcPlus4D   <= '0;
      predTakenD <= 1'b0;
      validD     <= 1'b0;
    end else if (mispredict) begin
      pc         <= redirect_pc;
      instrD     <= '0;
      pcPlus4D   <= '0;
      predTakenD <= 1'b0;
      validD     <= 1'b0;
    end else if (!stall) begin
      pc         <= next_pc;
      instrD     <= imemData;
      pcPlus4D   <= pc_plus4;
      predTakenD <= pred_taken;
      validD     <= 1'b1;
    end
  end

  // Branch history table: trained on every resolve, independent of stall.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this table is reset entry by entry on purpose. Every counter must
    // start weakly not-taken, so it builds as flops and not as a RAM macro.
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (resolveValid) begin
      bht[resolve_idx] <= resolve_ctr_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage_bp.sv
// Self-checking bench for fetch_stage_bp. A behavioural model tracks the PC,
// the IF/ID slot and the integer branch counters. The DUT is checked against
// it every cycle, first with directed scenarios and then with random stimulus.
module tb_fetch_stage_bp;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        resolveValid;
  logic        resolveTaken;
  logic [31:0] resolvePc;
  logic [31:0] resolveTarget;
  logic        resolvePredTaken;
  logic [31:0] instrD;
  logic [31:0] pcPlus4D;
  logic        predTakenD;
  logic        validD;
  logic        mispredict;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [31:0] m_pc;
  int          m_ctr [16];
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_pred;
  logic        m_valid;

  localparam logic [31:0] ADD_WORD = 32'h0022_0820;

  fetch_stage_bp dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imemAddr(imemAddr), .imemData(imemData),
    .resolveValid(resolveValid), .resolveTaken(resolveTaken),
    .resolvePc(resolvePc), .resolveTarget(resolveTarget),
    .resolvePredTaken(resolvePredTaken),
    .instrD(instrD), .pcPlus4D(pcPlus4D), .predTakenD(predTakenD),
    .validD(validD), .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = '0; m_pc4 = '0; m_pred = 1'b0; m_valid = 1'b0;
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
  endtask

  task automatic check_regs();
    check("instrD", instrD, m_instr);
    check("pcPlus4D", pcPlus4D, m_pc4);
    check("predTakenD", {31'b0, predTakenD}, {31'b0, m_pred});
    check("validD", {31'b0, validD}, {31'b0, m_valid});
  endtask

  // One clock: drive at the falling edge, check the combinational outputs,
  // advance the model, then check the registered outputs after the rising edge.
  task automatic step(input logic st, input logic [31:0] word, input logic rv,
                      input logic rt, input logic [31:0] rpc,
                      input logic [31:0] rtgt, input logic rpt);
    logic        exp_misp;
    logic        is_beq;
    logic        pred;
    int          fidx;
    int          ridx;
    int          simm;
    logic [31:0] tgt;
    stall = st; imemData = word; resolveValid = rv; resolveTaken = rt;
    resolvePc = rpc; resolveTarget = rtgt; resolvePredTaken = rpt;
    #1;
    exp_misp = rv && (rt != rpt);
    check("imemAddr", imemAddr, m_pc);
    check("mispredict", {31'b0, mispredict}, {31'b0, exp_misp});
    fidx   = int'((m_pc >> 2) % 16);
    is_beq = (word >> 26) == 32'd4;
    pred   = is_beq && (m_ctr[fidx] >= 2);
    simm   = int'($signed(word[15:0]));
    tgt    = m_pc + 32'd4 + 32'(simm * 4);
    if (exp_misp) begin
      m_pc = rt ? rtgt : rpc + 32'd4;
      m_instr = '0; m_pc4 = '0; m_pred = 1'b0; m_valid = 1'b0;
    end else if (!st) begin
      m_instr = word; m_pc4 = m_pc + 32'd4; m_pred = pred; m_valid = 1'b1;
      m_pc = pred ? tgt : m_pc + 32'd4;
    end
    if (rv) begin
      ridx = int'((rpc >> 2) % 16);
      if (rt) m_ctr[ridx] = (m_ctr[ridx] < 3) ? m_ctr[ridx] + 1 : 3;
      else    m_ctr[ridx] = (m_ctr[ridx] > 0) ? m_ctr[ridx] - 1 : 0;
    end
    @(posedge clk); #1;
    check_regs();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(1, 0) == 1) w[31:26] = 6'b000100;
    else if (w[31:26] == 6'b000100) w[31:26] = 6'b000000;
    return w;
  endfunction

  initial begin
    logic        rv, rt, rpt;
    logic [31:0] rpc, rtgt, w;
    rst = 1'b1; stall = 1'b0; imemData = ADD_WORD; resolveValid = 1'b0;
    resolveTaken = 1'b0; resolvePc = '0; resolveTarget = '0; resolvePredTaken = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_imemAddr", imemAddr, 32'h0);
    check_regs();
    rst = 1'b0;

    // Sequential fetch of adds: PC 0,4,8,C.
    for (int i = 0; i < 4; i++) step(1'b0, ADD_WORD, 1'b0, 1'b0, '0, '0, 1'b0);
    check("seq_pc_0x10", imemAddr, 32'h10);

    // beq at 0x10, imm=+3, weakly not-taken: resolve taken -> mispredict.
    step(1'b0, 32'h1022_0003, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, ADD_WORD, 1'b1, 1'b1, 32'h10, 32'h20, m_pred);
    check("redirect_0x20", imemAddr, 32'h20);
    step(1'b0, ADD_WORD, 1'b0, 1'b0, '0, '0, 1'b0);

    // Force refetch of 0x10; the counter is now weak-taken, so 0x10 -> 0x20.
    step(1'b0, ADD_WORD, 1'b1, 1'b1, 32'h40, 32'h10, 1'b0);
    step(1'b0, 32'h1022_0003, 1'b0, 1'b0, '0, '0, 1'b0);
    check("pred_taken_pc", imemAddr, 32'h20);
    check("pred_taken_bit", {31'b0, predTakenD}, 32'h1);
    step(1'b0, ADD_WORD, 1'b1, 1'b1, 32'h10, 32'h20, 1'b1);
    step(1'b0, ADD_WORD, 1'b1, 1'b1, 32'h10, 32'h20, 1'b1);
    // Two not-taken resolves: 11 -> 10 -> 01, then a predicted-taken instance
    // resolved not-taken redirects to 0x14.
    step(1'b0, ADD_WORD, 1'b1, 1'b0, 32'h10, 32'h20, 1'b0);
    step(1'b0, ADD_WORD, 1'b1, 1'b0, 32'h10, 32'h20, 1'b1);
    check("nt_redirect_0x14", imemAddr, 32'h14);

    // Stall for three cycles with a mispredict in the middle one.
    step(1'b1, ADD_WORD, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, ADD_WORD, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1);
    step(1'b1, ADD_WORD, 1'b0, 1'b0, '0, '0, 1'b0);
    check("stall_redirect_hold", imemAddr, 32'h84);

    // Train index 14 taken, jump to 0xFFFFFFF8, and a beq +1 there wraps to 0.
    step(1'b0, ADD_WORD, 1'b1, 1'b1, 32'h38, 32'h0, 1'b1);
    step(1'b0, ADD_WORD, 1'b1, 1'b1, 32'h38, 32'h0, 1'b1);
    step(1'b0, ADD_WORD, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFF8, 1'b0);
    step(1'b0, 32'h1000_0001, 1'b0, 1'b0, '0, '0, 1'b0);
    check("wrap_target", imemAddr, 32'h0);

    // Randomized traffic with realistic resolves plus stray same-index updates.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #1 rst = 1'b1;
        #1;
        check("async_rst_pc", imemAddr, 32'h0);
        check("async_rst_valid", {31'b0, validD}, 32'h0);
        #1 rst = 1'b0;
        model_reset();
      end
      w = rand_word();
      rv = 1'b0; rt = $urandom_range(1, 0); rpt = 1'b0; rpc = '0; rtgt = '0;
      if (m_valid && m_instr[31:26] == 6'b000100 && $urandom_range(3, 0) != 0) begin
        rv   = 1'b1;
        rpc  = m_pc4 - 32'd4;
        rpt  = m_pred;
        rtgt = m_pc4 + 32'(int'($signed(m_instr[15:0])) * 4);
      end else if ($urandom_range(7, 0) == 0) begin
        rv   = 1'b1;
        rpc  = m_pc;
        rpt  = $urandom_range(1, 0);
        rtgt = $urandom & 32'hFFFF_FFFC;
      end
      step($urandom_range(4, 0) == 0, w, rv, rt, rpc, rtgt, rpt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage_bp.md
Name: fetch_stage_bp

Overview:
- Instruction-fetch stage with a dynamic 2-bit saturating-counter branch predictor. It replaces static predict-not-taken.
- Holds the PC, pre-decodes each fetched word for beq, and steers the next PC from a branch history table (BHT).
- Drives the IF/ID pipeline register consumed by decode/control.
- Decode resolves beq (eq) and returns the outcome for redirect and predictor training.

Parameters:
- BHT_IDX_BITS, 4, log2 of BHT entries (16 entries); index = pc[BHT_IDX_BITS+1:2].
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall; hold PC and IF/ID.
- imemAddr  out  32  instruction memory address; equals PC, combinational read.
- imemData  in  32  instruction word at imemAddr, same cycle.
- resolveValid  in  1  decode holds a beq being resolved this cycle.
- resolveTaken  in  1  actual outcome (eq).
- resolvePc  in  32  PC of the resolving beq.
- resolveTarget  in  32  branch target computed in decode.
- resolvePredTaken  in  1  prediction that travelled with that beq.
- instrD  out  32  IF/ID instruction.
- pcPlus4D  out  32  IF/ID PC+4.
- predTakenD  out  1  IF/ID prediction bit for the fetched beq.
- validD  out  1  IF/ID slot holds a real instruction.
- mispredict  out  1  combinational; resolveValid & (resolveTaken != resolvePredTaken).

Behaviour:
- Reset, asynchronous:
  - PC=RESET_PC.
  - All BHT counters=2'b01 (weakly not-taken).
  - instrD=0 (nop), pcPlus4D=0, predTakenD=0, validD=0.
  - Deasserting rst mid-operation resumes fetch at RESET_PC on the next edge.
- Pre-decode:
  - isBeq = imemData[31:26]==6'b000100.
  - predTarget = PC+4 + {{14{imm[15]}}, imm[15:0], 2'b00}, 32-bit, wraps mod 2^32.
- Prediction: predTaken = isBeq & BHT[idx(PC)][1]. Non-beq words always predict not-taken.
- Next-PC priority, highest first:
  1. mispredict: PC ← resolveTaken ? resolveTarget : resolvePc+4. IF/ID ← nop with validD=0, predTakenD=0. This overrides stall.
  2. stall: PC, instrD, pcPlus4D, predTakenD, validD all hold.
  3. predTaken: PC ← predTarget.
  4. otherwise: PC ← PC+4.
- IF/ID load, when no mispredict and no stall: instrD=imemData, pcPlus4D=PC+4, predTakenD=predTaken, validD=1.
- BHT update:
  - On every edge with resolveValid=1, regardless of stall, at idx(resolvePc).
  - Taken: counter increments, saturating at 2'b11. Not-taken: decrements, saturating at 2'b00.
  - States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Read/write collision: if the same cycle both reads and updates an index, the read returns the pre-update value. The new value is visible next cycle.
- Correct prediction: no redirect, no flush, no bubble.
- Latency:
  - Fetch → instrD: 1 cycle.
  - Mispredict penalty: exactly 1 bubble (one validD=0 slot).
  - Correctly predicted taken branch: 0 bubbles.
- Aliasing: branches sharing idx share one counter; no tags.
- Ownership: the upstream hazard logic guarantees resolveValid is only asserted for a validD beq in decode.

Test Plan:
- Reset then release, imem returning add instructions → imemAddr 0,4,8,C on successive cycles; validD=0 in the first cycle after reset, then 1; all counters read 01.
- beq at PC 0x10, imm=+3, counter 01 → predicts not-taken. Resolve taken, resolveTarget=0x20 → mispredict=1, next PC=0x20, validD=0 for one cycle, counter becomes 10.
- Same beq fetched again → PC goes 0x10→0x20 directly, predTakenD=1. Resolve taken → no mispredict, counter saturates at 11. A further taken resolve leaves it at 11.
- Counter 11, two not-taken resolves → 10 then 01. A predicted-taken instance resolved not-taken redirects to resolvePc+4=0x14.
- stall=1 for 3 cycles with a mispredict on cycle 2 → PC/IF/ID hold on cycles 1 and 3; cycle 2 redirects and flushes despite stall.
- beq at 0xFFFFFFF8, imm=+1 → predTarget 0x00000000 (wrap). Assert rst mid-stream → PC=RESET_PC and validD=0 immediately, without waiting for a clock edge.
